// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO stage and its MulDiv neighbour:
// op encodings, FSM state type and the divide-by-zero LO value.
package md_pkg;

  localparam logic [3:0] MD_DIV   = 4'd0;
  localparam logic [3:0] MD_DIVU  = 4'd1;
  localparam logic [3:0] MD_MULT  = 4'd2;
  localparam logic [3:0] MD_MULTU = 4'd3;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } stateT;

  // Codes 4..15 are accepted but behave as a one-cycle no-op.
  function automatic logic isReserved(input logic [3:0] op);
    return op[3:2] != 2'b00;
  endfunction

  function automatic logic isDiv(input logic [3:0] op);
    return !isReserved(op) && !op[1];
  endfunction

endpackage

// File: rtl/hi_lo_unit.sv
// Architectural HI/LO registers around the external combinational MulDiv:
// registers operands, waits a per-op latency, then commits MulDiv's result.
module hi_lo_unit
  import md_pkg::*;
#(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        start,
  input  logic [3:0]  mdOp,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  output logic [3:0]  mdOpOut,
  output logic [31:0] opA,
  output logic [31:0] opB,
  input  logic [31:0] mdHi,
  input  logic [31:0] mdLo,
  input  logic        wrHi,
  input  logic        wrLo,
  input  logic [31:0] wdata,
  input  logic        rdSel,
  output logic [31:0] rdata,
  input  logic        abort,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  stateT       state, stateNext;
  logic [3:0]  cnt, cntNext;
  logic [31:0] hiQ, loQ;
  logic        accept, commit, divZero;

  assign divZero = isDiv(mdOpOut) && (opB == 32'd0);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    stateNext = state;
    cntNext   = cnt;
    accept    = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          accept    = 1'b1;
          stateNext = BUSY;
          if (isReserved(mdOp))
            cntNext = 4'd0;
          else
            cntNext = mdOp[1] ? MUL_CNT : DIV_CNT;
        end
      end
      BUSY: begin
        if (abort) begin
          stateNext = IDLE;
        end else if (cnt == 4'd0) begin
          commit    = !isReserved(mdOpOut);
          stateNext = IDLE;
        end else begin
          cntNext = cnt - 4'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Operands stay frozen until the next acceptance so MulDiv sees stable inputs.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mdOpOut <= 4'd0;
      opA     <= 32'd0;
      opB     <= 32'd0;
    end else if (accept) begin
      mdOpOut <= mdOp;
      opA     <= din1;
      opB     <= din2;
    end
  end

  // Commit only happens in BUSY and mthi/mtlo only in IDLE, so they never collide.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      hiQ <= 32'd0;
      loQ <= 32'd0;
    end else if (commit) begin
      hiQ <= divZero ? opA     : mdHi;
      loQ <= divZero ? DIV0_LO : mdLo;
    end else if (state == IDLE) begin
      if (wrHi) hiQ <= wdata;
      if (wrLo) loQ <= wdata;
    end
  end

  assign busy  = (state == BUSY);
  assign stall = busy & (start | wrHi | wrLo);
  assign rdata = rdSel ? loQ : hiQ;
  assign hi    = hiQ;
  assign lo    = loQ;

endmodule

// File: tb/tb_hi_lo_unit.sv
// Self-checking bench for hi_lo_unit: a behavioural MulDiv neighbour plus a
// transaction-level HI/LO model, directed cases and a randomized op stream.
module tb_hi_lo_unit;
  import md_pkg::*;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 8;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        start = 1'b0, start1 = 1'b0, abort = 1'b0;
  logic [3:0]  mdOp = 4'd0;
  logic [31:0] din1 = 32'd0, din2 = 32'd0, wdata = 32'd0;
  logic        wrHi = 1'b0, wrLo = 1'b0, rdSel = 1'b0, noWr = 1'b0;

  logic [3:0]  mdOpOut0, mdOpOut1;
  logic [31:0] opA0, opB0, opA1, opB1, mdHi0, mdLo0, mdHi1, mdLo1;
  logic [31:0] rdata0, rdata1, hi0, lo0, hi1, lo1;
  logic        busy0, stall0, busy1, stall1;

  always #5 clk = ~clk;

  // Behavioural MulDiv: {HI,LO}. Divide by zero returns junk the DUT must ignore.
  function automatic logic [63:0] arith(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint pa, pb;
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    arith = 64'd0;
    case (op)
      MD_DIV: begin
        if (b == 32'd0) arith = {32'hBAD0_BAD0, 32'h0BAD_0BAD};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) arith = {32'd0, a};
        else arith = {32'(sa % sb), 32'(sa / sb)};
      end
      MD_DIVU: begin
        if (b == 32'd0) arith = {32'hBAD1_BAD1, 32'h1BAD_1BAD};
        else arith = {a % b, a / b};
      end
      MD_MULT: begin
        pa = longint'(sa);
        pb = longint'(sb);
        arith = 64'(pa * pb);
      end
      MD_MULTU: arith = {32'd0, a} * {32'd0, b};
      default: arith = {32'hCAFE_F00D, 32'hCAFE_F00D};
    endcase
  endfunction

  assign {mdHi0, mdLo0} = arith(mdOpOut0, opA0, opB0);
  assign {mdHi1, mdLo1} = arith(mdOpOut1, opA1, opB1);

  hi_lo_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rstN(rstN), .start(start), .mdOp(mdOp), .din1(din1), .din2(din2),
    .mdOpOut(mdOpOut0), .opA(opA0), .opB(opB0), .mdHi(mdHi0), .mdLo(mdLo0),
    .wrHi(wrHi), .wrLo(wrLo), .wdata(wdata), .rdSel(rdSel), .rdata(rdata0),
    .abort(abort), .busy(busy0), .stall(stall0), .hi(hi0), .lo(lo0)
  );

  hi_lo_unit #(.MUL_LAT(1), .DIV_LAT(2)) dutFast (
    .clk(clk), .rstN(rstN), .start(start1), .mdOp(mdOp), .din1(din1), .din2(din2),
    .mdOpOut(mdOpOut1), .opA(opA1), .opB(opB1), .mdHi(mdHi1), .mdLo(mdLo1),
    .wrHi(noWr), .wrLo(noWr), .wdata(wdata), .rdSel(rdSel), .rdata(rdata1),
    .abort(abort), .busy(busy1), .stall(stall1), .hi(hi1), .lo(lo1)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] expHi = 32'd0, expLo = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request from IDLE; abortAt=k raises abort for the edge E0+k.
  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int abortAt, input bit probe, input bit wrWith);
    int lat;
    logic [63:0] res;
    logic [31:0] wv;
    bit reserved;
    reserved = (op >= 4'd4);
    lat = reserved ? 1 : (op[1] ? MUL_LAT : DIV_LAT);
    res = (!op[1] && b == 32'd0) ? {a, DIV0_LO} : arith(op, a, b);
    wv = $urandom;
    mdOp = op; din1 = a; din2 = b; start = 1'b1;
    if (wrWith) begin wrHi = 1'b1; wdata = wv; end
    tick();
    start = 1'b0; wrHi = 1'b0;
    din1 = $urandom; din2 = $urandom; mdOp = 4'($urandom);
    check("busyAtE0", busy0, 1'b1);
    if (wrWith) begin
      expHi = wv;
      check("mthiWithStart", hi0, expHi);
    end
    for (int k = 1; k <= lat; k++) begin
      if (abortAt == k) abort = 1'b1;
      if (probe) begin
        start = 1'b1; wrHi = 1'b1; wdata = $urandom;
        #1;
        check("stallWhileBusy", stall0, 1'b1);
      end
      tick();
      abort = 1'b0; start = 1'b0; wrHi = 1'b0;
      if (abortAt == k) begin
        check("busyAfterAbort", busy0, 1'b0);
        check("hiAfterAbort", hi0, expHi);
        check("loAfterAbort", lo0, expLo);
        repeat (lat) tick();
        check("noLateCommit", hi0, expHi);
        return;
      end
      if (k < lat) begin
        check("busyHold", busy0, 1'b1);
        check("hiHold", hi0, expHi);
        check("opAHold", opA0, a);
      end else begin
        check("busyDone", busy0, 1'b0);
        if (!reserved) begin
          expHi = res[63:32];
          expLo = res[31:0];
        end
        check("hiCommit", hi0, expHi);
        check("loCommit", lo0, expLo);
      end
    end
  endtask

  // mthi/mtlo from IDLE with no forwarding of the write in its own cycle.
  task automatic doWrite(input bit h, input bit l, input logic [31:0] v);
    rdSel = 1'b0; wrHi = h; wrLo = l; wdata = v;
    #1;
    check("rdNoForward", rdata0, expHi);
    tick();
    wrHi = 1'b0; wrLo = 1'b0;
    if (h) expHi = v;
    if (l) expLo = v;
    check("hiWrite", hi0, expHi);
    check("loWrite", lo0, expLo);
    check("rdataHi", rdata0, expHi);
    rdSel = 1'b1;
    #1;
    check("rdataLo", rdata0, expLo);
    rdSel = 1'b0;
  endtask

  initial begin
    int lat, abortAt;
    logic [3:0] op;
    logic [31:0] a, b;

    repeat (2) @(posedge clk);
    #1;
    check("rstHi", hi0, 32'd0);
    check("rstLo", lo0, 32'd0);
    check("rstOpA", opA0, 32'd0);
    check("rstOpB", opB0, 32'd0);
    check("rstMdOp", {28'd0, mdOpOut0}, 32'd0);
    check("rstBusy", busy0, 1'b0);
    check("rstStall", stall0, 1'b0);
    @(negedge clk) rstN = 1'b1;
    tick();

    runOp(MD_DIV, 32'd5, 32'hFFFF_FFFD, 0, 1'b0, 1'b0);
    check("div5byM3Hi", hi0, 32'h0000_0002);
    runOp(MD_MULTU, 32'hABCD_CDEF, 32'h1234_5678, 0, 1'b0, 1'b0);
    check("multuLo", lo0, 32'h4E32_D208);
    runOp(MD_MULT, 32'hFFFF_FFFB, 32'd3, 0, 1'b1, 1'b0);
    check("multNegLo", lo0, 32'hFFFF_FFF1);
    doWrite(1'b1, 1'b0, 32'hDEAD_BEEF);
    doWrite(1'b1, 1'b1, 32'h1357_9BDF);
    doWrite(1'b0, 1'b1, 32'h0246_8ACE);
    runOp(MD_DIVU, 32'd100, 32'd7, 3, 1'b0, 1'b0);
    runOp(MD_DIVU, 32'd7, 32'd0, 0, 1'b0, 1'b0);
    check("divuZeroHi", hi0, 32'd7);
    runOp(MD_DIV, 32'hFFFF_FFF0, 32'd0, 0, 1'b0, 1'b0);
    runOp(4'd9, 32'd1, 32'd2, 0, 1'b0, 1'b0);
    runOp(MD_MULT, 32'd6, 32'd7, 0, 1'b0, 1'b1);

    // abort together with start in IDLE rejects the request
    mdOp = MD_MULT; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("abortStartRejected", busy0, 1'b0);

    // asynchronous reset in the middle of a mult
    mdOp = MD_MULT; din1 = 32'd9; din2 = 32'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 rstN = 1'b0;
    #1;
    check("midRstHi", hi0, 32'd0);
    check("midRstLo", lo0, 32'd0);
    check("midRstBusy", busy0, 1'b0);
    expHi = 32'd0; expLo = 32'd0;
    @(negedge clk) rstN = 1'b1;
    repeat (MUL_LAT + 1) tick();
    check("noCommitAfterRst", hi0, 32'd0);
    check("busyAfterRst", busy0, 1'b0);

    // MUL_LAT=1 instance commits one edge after acceptance
    mdOp = MD_MULT; din1 = 32'hFFFF_FFFB; din2 = 32'd3; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check("fastBusyE0", busy1, 1'b1);
    tick();
    check("fastBusyE1", busy1, 1'b0);
    check("fastHi", hi1, 32'hFFFF_FFFF);
    check("fastLo", lo1, 32'hFFFF_FFF1);

    for (int i = 0; i < 30; i++) begin
      op = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
      lat = (op >= 4'd4) ? 1 : (op[1] ? MUL_LAT : DIV_LAT);
      abortAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat)) : 0;
      runOp(op, a, b, abortAt, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0)
        doWrite(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
